// File: rtl/seven_seg_pkg.sv
// Shared constants for the multiplexed seven-segment digit scanner.
package seven_seg_pkg;
  localparam int   DIGIT_W          = 4;
  localparam logic EN_ACTIVE        = 1'b0;
  localparam logic EN_IDLE          = 1'b1;
  localparam int   NUM_DIGITS_DEF   = 3;
  localparam int   REFRESH_DIV_DEF  = 12000;
  localparam int   GHOST_CYCLES_DEF = 120;
endpackage

// File: rtl/seven_seg_if.sv
// Value-load handshake and display-side signals of the digit scanner.
interface seven_seg_if
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS = NUM_DIGITS_DEF
);
  logic [DIGIT_W*NUM_DIGITS-1:0] iVALUE;
  logic                          iLOAD;
  logic                          oBUSY;
  logic [DIGIT_W-1:0]            oDIG;
  logic [NUM_DIGITS-1:0]         oEN;
  logic                          oFRAME;

  modport master (output iVALUE, iLOAD, input oBUSY, oDIG, oEN, oFRAME);
  modport slave  (input iVALUE, iLOAD, output oBUSY, oDIG, oEN, oFRAME);
endinterface

// File: rtl/seven_seg_prescaler.sv
// Slot timebase: divides the clock into digit slots and flags the ghost
// interval and the last cycle of each frame.
module seven_seg_prescaler #(
  parameter int NUM_DIGITS   = 3,
  parameter int REFRESH_DIV  = 12000,
  parameter int GHOST_CYCLES = 120,
  localparam int SLOT_W      = $clog2(NUM_DIGITS),
  localparam int PRESC_W     = $clog2(REFRESH_DIV)
) (
  input  logic              clk,
  input  logic              rst,
  output logic [SLOT_W-1:0] slot,
  output logic              in_ghost,
  output logic              boundary
);
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [SLOT_W-1:0]  slot_q, slot_d;
  logic               wrap;

  always_comb begin
    wrap     = (presc_q == PRESC_W'(REFRESH_DIV - 1));
    presc_d  = presc_q + PRESC_W'(1);
    slot_d   = slot_q;
    if (wrap) begin
      presc_d = '0;
      slot_d  = (slot_q == SLOT_W'(NUM_DIGITS - 1)) ? '0 : slot_q + SLOT_W'(1);
    end
    in_ghost = (presc_q < PRESC_W'(GHOST_CYCLES));
    boundary = wrap && (slot_q == SLOT_W'(NUM_DIGITS - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      slot_q  <= '0;
    end else begin
      presc_q <= presc_d;
      slot_q  <= slot_d;
    end
  end

  assign slot = slot_q;
endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed digit scanner with frame-synchronous value loading.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 always shown).
module seven_seg_scanner
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS   = NUM_DIGITS_DEF,
  parameter int REFRESH_DIV  = REFRESH_DIV_DEF,
  parameter int GHOST_CYCLES = GHOST_CYCLES_DEF,
  localparam int SLOT_W      = $clog2(NUM_DIGITS),
  localparam int VAL_W       = DIGIT_W * NUM_DIGITS
) (
  input  logic      iCLK,
  input  logic      iRST,
  seven_seg_if.slave bus
);
  logic [SLOT_W-1:0]     slot;
  logic                  in_ghost, boundary;
  logic [VAL_W-1:0]      display_q, display_d, pending_q, pending_d;
  logic                  busy_q, busy_d;
  logic [DIGIT_W-1:0]    dig_q, dig_d;
  logic [NUM_DIGITS-1:0] en_q, en_d, blank;
  logic                  frame_q, frame_d, start_q;

  seven_seg_prescaler #(
    .NUM_DIGITS  (NUM_DIGITS),
    .REFRESH_DIV (REFRESH_DIV),
    .GHOST_CYCLES(GHOST_CYCLES)
  ) u_prescaler (
    .clk     (iCLK),
    .rst     (iRST),
    .slot    (slot),
    .in_ghost(in_ghost),
    .boundary(boundary)
  );

  // A load landing on the boundary wins outright over any older pending value.
  always_comb begin
    display_d = display_q;
    pending_d = pending_q;
    busy_d    = busy_q;
    if (boundary) begin
      busy_d = 1'b0;
      if (bus.iLOAD)   display_d = bus.iVALUE;
      else if (busy_q) display_d = pending_q;
    end else if (bus.iLOAD) begin
      pending_d = bus.iVALUE;
      busy_d    = 1'b1;
    end
  end

  always_comb begin
    blank = '0;
`ifdef LEADING_ZERO_BLANK_EN
    begin
      logic zero_above;
      zero_above = 1'b1;
      for (int k = NUM_DIGITS - 1; k > 0; k--) begin
        zero_above = zero_above && (display_q[k*DIGIT_W +: DIGIT_W] == '0);
        blank[k]   = zero_above;
      end
    end
`endif
    dig_d = '0;
    en_d  = {NUM_DIGITS{EN_IDLE}};
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (slot == SLOT_W'(k)) begin
        dig_d = display_q[k*DIGIT_W +: DIGIT_W];
        if (!in_ghost && !blank[k]) en_d[k] = EN_ACTIVE;
      end
    end
    // start_q resets high so the first slot-0 cycle after reset is also framed.
    frame_d = start_q;
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      display_q <= '0;
      pending_q <= '0;
      busy_q    <= 1'b0;
      dig_q     <= '0;
      en_q      <= {NUM_DIGITS{EN_IDLE}};
      frame_q   <= 1'b0;
      start_q   <= 1'b1;
    end else begin
      display_q <= display_d;
      pending_q <= pending_d;
      busy_q    <= busy_d;
      dig_q     <= dig_d;
      en_q      <= en_d;
      frame_q   <= frame_d;
      start_q   <= boundary;
    end
  end

  assign bus.oBUSY  = busy_q;
  assign bus.oDIG   = dig_q;
  assign bus.oEN    = en_q;
  assign bus.oFRAME = frame_q;
endmodule
